rssb_ctrl: RTL and testbench
============================

# rssb_ctrl

Sequencer for the RSSB (reverse-subtract, skip-if-borrow) core. It drives the single-port data memory, whose ROM occupies addresses with MSB=1 and RAM those with MSB=0. Each instruction runs as a two-cycle fetch/execute loop: read an operand address, compute mem[A] − ACC, write the result back, and advance PC by 1, or by 2 on borrow. The block owns PC, ACC, the borrow flag, a retired-instruction counter and run/halt control.

## Interface
- WIDTH, 8, data/address width; ROM/RAM select is address bit WIDTH-1
- RESET_PC, 8'h80, PC value after reset and on every start from IDLE (first ROM word)
- HALT_OP, 8'hFF, operand value that halts the core when fetched
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level-sampled in IDLE/HALT; begins execution at RESET_PC
- stop  in  1  request to return to IDLE after the current instruction retires
- mem_rdata  in  WIDTH  memory read data, combinational from mem_addr
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_write  out  1  memory write strobe, committed on the rising edge
- pc  out  WIDTH  program counter
- acc  out  WIDTH  accumulator
- borrow  out  1  borrow of the last executed instruction
- busy  out  1  high in FETCH or EXEC
- halted  out  1  high in HALT
- icount  out  16  retired-instruction count, wraps at 16'hFFFF

## Operation
- States: IDLE, FETCH, EXEC, HALT. Reset enters IDLE.
- Reset values: pc=RESET_PC, acc=0, borrow=0, icount=0, operand register opr=0, halted=0, busy=0, mem_write=0.
- **IDLE:** mem_addr=pc, mem_write=0. When start=1, load pc<=RESET_PC, clear acc, borrow and icount, and go to FETCH.
- **FETCH:** mem_addr=pc, opr<=mem_rdata.
  - mem_rdata==HALT_OP: go to HALT; pc, acc and icount are unchanged.
  - Otherwise go to EXEC.
- **EXEC:** mem_addr=opr. Compute R=(mem_rdata−acc) mod 2^WIDTH and B=(mem_rdata<acc), unsigned.
  - acc<=R, borrow<=B.
  - pc<=pc+1+B, mod 2^WIDTH; wrap from 8'hFF to 8'h00/8'h01 is legal.
  - icount<=icount+1.
  - mem_wdata=R. mem_write=1 only if opr[WIDTH-1]==0 (RAM). Writes to ROM addresses are suppressed; acc and pc still update.
  - Next state: IDLE if stop was sampled high during FETCH or EXEC of this instruction, else FETCH.
- **HALT:** mem_addr=pc, mem_write=0, halted=1. start=1 restarts exactly as from IDLE. stop is ignored.
- stop in IDLE is ignored. stop and start together in IDLE: start wins.
- A pending stop is latched in a one-bit register and cleared on entry to IDLE.

## Timing
- An instruction takes 2 cycles (FETCH, EXEC). Throughput is one instruction per 2 clocks.
- mem_addr, mem_wdata and mem_write are combinational from state and registers. No output depends combinationally on start or stop.
- The RAM write and the acc/pc update occur on the same edge that ends EXEC.
- The read in EXEC returns the pre-write value because the write commits at the edge.
- Asynchronous rst mid-instruction: immediate return to IDLE with reset values; mem_write drops in the same instant. A partially executed instruction leaves memory unmodified.
- Reaching HALT takes one cycle (FETCH) after the preceding EXEC.

## Test plan
- **Reset mid-EXEC:**
  - Stimulus: assert rst while mem_write=1.
  - Required: mem_write=0 immediately; pc=8'h80, acc=0, icount=0, busy=0; RAM word unchanged.
- **Single instruction, no borrow:**
  - Stimulus: ROM[80]=8'h10, RAM[10]=8'h05, acc=0, start pulse.
  - Required: after 2 cycles in the loop, acc=8'h05, RAM[10]=8'h05, borrow=0, pc=8'h81, icount=1.
- **Borrow skip:**
  - Stimulus: ROM[81]=8'h11, RAM[11]=8'h03, with acc=8'h05 from the previous instruction.
  - Required: acc=8'hFE, RAM[11]=8'hFE, borrow=1, pc=8'h83 (8'h82 skipped).
- **ROM-target write suppression:**
  - Stimulus: operand 8'h90, ROM[90]=8'h07, acc=8'h02.
  - Required: mem_write stays 0 throughout EXEC; acc=8'h05, pc advances by 1.
- **Halt and restart:**
  - Stimulus: ROM[83]=8'hFF.
  - Required: FETCH→HALT, halted=1, pc=8'h83, icount unchanged. A later start gives pc=8'h80, icount=0, busy=1.
- **Stop request and PC wrap:**
  - Stimulus: stop pulsed during FETCH.
  - Required: the instruction retires, then IDLE with busy=0. Separately, borrow at pc=8'hFF gives pc=8'h01.

Source files
------------

// File: rtl/rssb_if.sv
// rssb_if: bus bundle between the RSSB sequencer and its environment.
//   master : controller side (drives memory address/data/strobe and status,
//            samples start/stop and memory read data)
//   slave  : environment side (memory model + run control)
// Ports carried: start, stop, mem_rdata, mem_addr, mem_wdata, mem_write,
//                pc, acc, borrow, busy, halted, icount.
interface rssb_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_write;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] acc;
  logic             borrow;
  logic             busy;
  logic             halted;
  logic [15:0]      icount;

  modport master (
    input  start, stop, mem_rdata,
    output mem_addr, mem_wdata, mem_write, pc, acc, borrow, busy, halted, icount
  );

  modport slave (
    output start, stop, mem_rdata,
    input  mem_addr, mem_wdata, mem_write, pc, acc, borrow, busy, halted, icount
  );
endinterface

// File: rtl/rssb_ctrl.sv
// rssb_ctrl: two-cycle fetch/execute sequencer for the RSSB core.
//   FETCH reads the operand word at pc; EXEC reads mem[opr], computes
//   mem[opr]-acc, writes it back (RAM only, MSB=0) and steps pc by 1,
//   or by 2 when the subtraction borrows.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - rssb_if.master: start/stop run control, single-port memory
//          (mem_addr/mem_rdata/mem_wdata/mem_write) and status outputs
//          (pc, acc, borrow, busy, halted, icount).
module rssb_ctrl #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = 8'h80,
  parameter logic [WIDTH-1:0] HALT_OP  = 8'hFF
) (
  input logic   clk,
  input logic   rst,
  rssb_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opr;
  logic             borrow_q;
  logic [15:0]      icount_q;
  logic             stop_pend;

  // One extra bit on the subtraction: its MSB is the unsigned borrow.
  logic [WIDTH:0]   sub;
  logic             brw;
  assign sub = {1'b0, bus.mem_rdata} - {1'b0, acc_q};
  assign brw = sub[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_q      <= RESET_PC;
      acc_q     <= '0;
      opr       <= '0;
      borrow_q  <= 1'b0;
      icount_q  <= '0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          // stop is meaningless while not running; never carry it into a run.
          stop_pend <= 1'b0;
          if (bus.start) begin
            state    <= S_FETCH;
            pc_q     <= RESET_PC;
            acc_q    <= '0;
            borrow_q <= 1'b0;
            icount_q <= '0;
          end
        end
        S_FETCH: begin
          opr <= bus.mem_rdata;
          if (bus.stop) stop_pend <= 1'b1;
          state <= (bus.mem_rdata == HALT_OP) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          acc_q    <= sub[WIDTH-1:0];
          borrow_q <= brw;
          pc_q     <= pc_q + {{(WIDTH-1){1'b0}}, 1'b1} + {{(WIDTH-1){1'b0}}, brw};
          icount_q <= icount_q + 16'd1;
          if (stop_pend || bus.stop) begin
            state     <= S_IDLE;
            stop_pend <= 1'b0;
          end else begin
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory side is purely state/register driven, so rst kills the write
  // strobe in the same instant it forces IDLE.
  assign bus.mem_addr  = (state == S_EXEC) ? opr : pc_q;
  assign bus.mem_wdata = sub[WIDTH-1:0];
  assign bus.mem_write = (state == S_EXEC) && !opr[WIDTH-1];

  assign bus.pc     = pc_q;
  assign bus.acc    = acc_q;
  assign bus.borrow = borrow_q;
  assign bus.icount = icount_q;
  assign bus.busy   = (state == S_FETCH) || (state == S_EXEC);
  assign bus.halted = (state == S_HALT);

endmodule

// File: tb/tb_rssb_ctrl.sv
// tb_rssb_ctrl: directed test of rssb_ctrl with a 256-byte memory model.
module tb_rssb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rssb_if #(.WIDTH(8)) bus();

  rssb_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: DUT writes and bench preloads share one process.
  bit [7:0]   mem [256];
  logic       ld_en   = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    if (ld_en)         mem[ld_addr]      <= ld_data;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    #12;
    // Reset state
    chk("rst_pc",     bus.pc, 32'h80);
    chk("rst_acc",    bus.acc, 32'h0);
    chk("rst_borrow", bus.borrow, 32'h0);
    chk("rst_icount", bus.icount, 32'h0);
    chk("rst_busy",   bus.busy, 32'h0);
    chk("rst_halted", bus.halted, 32'h0);
    chk("rst_mwr",    bus.mem_write, 32'h0);
    rst = 1'b0;
    tick();

    // Program: 80:10, 81:11, 83:FF ; RAM 10=05, 11=03
    ld(8'h80, 8'h10); ld(8'h81, 8'h11); ld(8'h83, 8'hFF);
    ld(8'h10, 8'h05); ld(8'h11, 8'h03);
    chk("idle_stays", bus.busy, 32'h0);

    go();                                   // FETCH @80
    chk("fetch_busy", bus.busy, 32'h1);
    tick();                                 // EXEC op 10
    chk("exec1_addr", bus.mem_addr, 32'h10);
    chk("exec1_mwr",  bus.mem_write, 32'h1);
    chk("exec1_wdat", bus.mem_wdata, 32'h05);
    tick();                                 // FETCH @81
    chk("i1_acc",    bus.acc, 32'h05);
    chk("i1_borrow", bus.borrow, 32'h0);
    chk("i1_pc",     bus.pc, 32'h81);
    chk("i1_icount", bus.icount, 32'h1);
    chk("i1_ram10",  mem[8'h10], 32'h05);
    tick(); tick();                         // EXEC op 11, FETCH @83
    chk("i2_acc",    bus.acc, 32'hFE);
    chk("i2_borrow", bus.borrow, 32'h1);
    chk("i2_pc",     bus.pc, 32'h83);
    chk("i2_ram11",  mem[8'h11], 32'hFE);
    chk("i2_icount", bus.icount, 32'h2);
    tick();                                 // HALT
    chk("halt_flag",   bus.halted, 32'h1);
    chk("halt_busy",   bus.busy, 32'h0);
    chk("halt_pc",     bus.pc, 32'h83);
    chk("halt_icount", bus.icount, 32'h2);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk("halt_stop_ign", bus.halted, 32'h1);

    // Restart from HALT, stop during first FETCH
    go();
    chk("rs_pc",     bus.pc, 32'h80);
    chk("rs_icount", bus.icount, 32'h0);
    chk("rs_busy",   bus.busy, 32'h1);
    chk("rs_acc",    bus.acc, 32'h0);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;   // EXEC
    chk("stop_exec_busy", bus.busy, 32'h1);
    tick();                                     // IDLE
    chk("stop_idle_busy", bus.busy, 32'h0);
    chk("stop_acc",       bus.acc, 32'h05);
    chk("stop_pc",        bus.pc, 32'h81);
    chk("stop_icount",    bus.icount, 32'h1);
    tick();
    chk("stop_stay_idle", bus.busy, 32'h0);

    // start+stop in IDLE: start wins, stop not remembered
    bus.start = 1'b1; bus.stop = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
    chk("ss_busy", bus.busy, 32'h1);
    tick(); tick();                             // EXEC, FETCH @81
    chk("ss_no_pend", bus.busy, 32'h1);
    chk("ss_pc",      bus.pc, 32'h81);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;   // EXEC op 11: FE-05
    tick();
    chk("ss2_busy", bus.busy, 32'h0);
    chk("ss2_acc",  bus.acc, 32'hF9);
    chk("ss2_pc",   bus.pc, 32'h82);

    // Reset mid-EXEC of second instruction (RAM11=F9, acc=05)
    go(); tick(); tick(); tick();
    chk("mid_mwr_pre", bus.mem_write, 32'h1);
    chk("mid_wdat",    bus.mem_wdata, 32'hF4);
    #1 rst = 1'b1;
    #1;
    chk("mid_mwr",    bus.mem_write, 32'h0);
    chk("mid_pc",     bus.pc, 32'h80);
    chk("mid_acc",    bus.acc, 32'h0);
    chk("mid_icount", bus.icount, 32'h0);
    chk("mid_busy",   bus.busy, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_ram11", mem[8'h11], 32'hF9);

    // ROM-target suppression: 80:12, 12=02, 81:90, ROM 90=07, 82:FF
    ld(8'h80, 8'h12); ld(8'h12, 8'h02); ld(8'h81, 8'h90);
    ld(8'h90, 8'h07); ld(8'h82, 8'hFF);
    go(); tick(); tick();                   // FETCH @81, acc=02
    chk("rom_acc_pre", bus.acc, 32'h02);
    tick();                                 // EXEC op 90
    chk("rom_addr", bus.mem_addr, 32'h90);
    chk("rom_mwr",  bus.mem_write, 32'h0);
    @(negedge clk);
    chk("rom_mwr_neg", bus.mem_write, 32'h0);
    @(posedge clk); #1;                     // FETCH @82
    chk("rom_acc",   bus.acc, 32'h05);
    chk("rom_pc",    bus.pc, 32'h82);
    chk("rom_bor",   bus.borrow, 32'h0);
    chk("rom_kept",  mem[8'h90], 32'h07);
    tick();
    chk("rom_halt",  bus.halted, 32'h1);

    // PC wrap: ROM 80..FE = 80 (acc alternates 80/00), FF:30, RAM30=10, RAM01=FF
    for (int a = 8'h80; a < 8'hFF; a++) ld(8'(a), 8'h80);
    ld(8'hFF, 8'h30); ld(8'h30, 8'h10); ld(8'h01, 8'hFF);
    go();
    for (int i = 0; i < 400 && !bus.halted; i++) tick();
    chk("wrap_halted", bus.halted, 32'h1);
    chk("wrap_pc",     bus.pc, 32'h01);
    chk("wrap_acc",    bus.acc, 32'h90);
    chk("wrap_borrow", bus.borrow, 32'h1);
    chk("wrap_icount", bus.icount, 32'd128);
    chk("wrap_ram30",  mem[8'h30], 32'h90);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
